// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer types and constants
// Purpose: controller state encoding, default framebuffer geometry and
// 640x480@60 VGA timing constants shared with VGAController.
// Ports: none (package).
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD1    = 3'd2,
    ST_RD2    = 3'd3,
    ST_FSETUP = 3'd4,
    ST_FRUN   = 3'd5,
    ST_FDONE  = 3'd6
  } fb_state_t;

  localparam int DEF_PIXEL_WIDTH = 1;
  localparam int DEF_H_RES       = 640;
  localparam int DEF_V_RES       = 480;

  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_TOTAL = DEF_H_RES + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_TOTAL = DEF_V_RES + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - clipped rectangle raster walker
// Purpose: clips a rectangle to the screen, then walks it in raster order,
// one pixel per step, producing the linear framebuffer address.
// Ports:
//   clock, reset        - clock, asynchronous active-high reset
//   load                - latch corners, clip and compute the first row base
//   step                - advance to the next pixel
//   x0, y0, x1, y1      - inclusive rectangle corners
//   addr                - linear address of the current pixel
//   valid               - current pixel exists (rectangle non-empty, not finished)
//   last                - current pixel is the final one of the rectangle
module fb_rect_walker
  import fb_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int ADDR_WIDTH  = 19,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y1,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   valid,
  output logic                   last
);

  localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(H_RES - 1);
  localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(V_RES - 1);

  logic [COORD_WIDTH-1:0] x_clip, y_clip;
  logic                   empty;

  logic [COORD_WIDTH-1:0] x, y, x_start, x_end, y_end;
  logic [ADDR_WIDTH-1:0]  row_base;

  assign x_clip = (x1 > X_MAX) ? X_MAX : x1;
  assign y_clip = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty  = (x0 > x_clip) || (y0 > y_clip);

  assign addr = row_base + ADDR_WIDTH'(x);
  assign last = valid && (x == x_end) && (y == y_end);

  // Row base advances by H_RES per row so the run phase needs no multiplier;
  // the last pixel is never stepped past, so row_base never exceeds the screen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x_start  <= x0;
      x_end    <= x_clip;
      y_end    <= y_clip;
      row_base <= ADDR_WIDTH'(y0) * ADDR_WIDTH'(H_RES);
      valid    <= !empty;
    end else if (step && valid) begin
      if (x == x_end) begin
        if (y == y_end) begin
          valid <= 1'b0;
        end else begin
          x        <= x_start;
          y        <= y + COORD_WIDTH'(1);
          row_base <= row_base + ADDR_WIDTH'(H_RES);
        end
      end else begin
        x <= x + COORD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_fb_ctrl.sv
// rtl/pixel_fb_ctrl.sv - framebuffer port-0 arbiter with rectangle fill
// Purpose: arbitrates CPU single-pixel reads/writes against a one-pixel-per-
// cycle rectangle fill engine onto DPRAM port 0.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   cpu_addr/din/we/re           - CPU request (levels, held until cpu_ack)
//   cpu_dout, cpu_ack            - registered read data, one-cycle ack
//   fill_start, fill_x0..y1      - fill request pulse and inclusive corners
//   fill_color                   - fill value
//   busy, fill_done              - fill pending/running, completion pulse
//   ram_addr/din/we, ram_dout    - DPRAM port 0 (read data one cycle late)
module pixel_fb_ctrl
  import fb_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int ADDR_WIDTH  = 19,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [PIXEL_WIDTH-1:0] cpu_din,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  output logic [PIXEL_WIDTH-1:0] cpu_dout,
  output logic                   cpu_ack,
  input  logic                   fill_start,
  input  logic [COORD_WIDTH-1:0] fill_x0,
  input  logic [COORD_WIDTH-1:0] fill_y0,
  input  logic [COORD_WIDTH-1:0] fill_x1,
  input  logic [COORD_WIDTH-1:0] fill_y1,
  input  logic [PIXEL_WIDTH-1:0] fill_color,
  output logic                   busy,
  output logic                   fill_done,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [PIXEL_WIDTH-1:0] ram_din,
  output logic                   ram_we,
  input  logic [PIXEL_WIDTH-1:0] ram_dout
);

  fb_state_t              state;
  logic [COORD_WIDTH-1:0] fx0, fy0, fx1, fy1;
  logic [PIXEL_WIDTH-1:0] fcolor;
  logic                   last_issued;

  logic                   walk_load, walk_step, walk_valid, walk_last;
  logic [ADDR_WIDTH-1:0]  walk_addr;

  // The walker is loaded on entry to FSETUP so its first pixel is ready to
  // issue at the FSETUP edge; it then stays one pixel ahead of ram_addr.
  assign walk_load = (state == ST_IDLE) && busy && !cpu_we && !cpu_re;
  assign walk_step = ((state == ST_FSETUP) && walk_valid) ||
                     ((state == ST_FRUN) && !last_issued);

  fb_rect_walker #(
    .H_RES       (H_RES),
    .V_RES       (V_RES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COORD_WIDTH (COORD_WIDTH)
  ) u_walker (
    .clock (clock),
    .reset (reset),
    .load  (walk_load),
    .step  (walk_step),
    .x0    (fx0),
    .y0    (fy0),
    .x1    (fx1),
    .y1    (fy1),
    .addr  (walk_addr),
    .valid (walk_valid),
    .last  (walk_last)
  );

  // busy doubles as the pending-fill flag: set on accept, cleared leaving FDONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      fill_done   <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      fx0         <= '0;
      fy0         <= '0;
      fx1         <= '0;
      fy1         <= '0;
      fcolor      <= '0;
      last_issued <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      fill_done <= 1'b0;
      ram_we    <= 1'b0;

      if (fill_start && !busy) begin
        busy   <= 1'b1;
        fx0    <= fill_x0;
        fy0    <= fill_y0;
        fx1    <= fill_x1;
        fy1    <= fill_y1;
        fcolor <= fill_color;
      end

      case (state)
        ST_IDLE: begin
          if (cpu_we) begin
            ram_addr <= cpu_addr;
            ram_din  <= cpu_din;
            ram_we   <= 1'b1;
            cpu_ack  <= 1'b1;
            state    <= ST_WR;
          end else if (cpu_re) begin
            ram_addr <= cpu_addr;
            state    <= ST_RD1;
          end else if (busy) begin
            state <= ST_FSETUP;
          end
        end
        ST_WR:  state <= ST_IDLE;
        ST_RD1: state <= ST_RD2;
        ST_RD2: begin
          cpu_dout <= ram_dout;
          cpu_ack  <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_FSETUP: begin
          if (walk_valid) begin
            ram_addr    <= walk_addr;
            ram_din     <= fcolor;
            ram_we      <= 1'b1;
            last_issued <= walk_last;
            state       <= ST_FRUN;
          end else begin
            fill_done <= 1'b1;
            state     <= ST_FDONE;
          end
        end
        ST_FRUN: begin
          if (last_issued) begin
            fill_done <= 1'b1;
            state     <= ST_FDONE;
          end else begin
            ram_addr    <= walk_addr;
            ram_din     <= fcolor;
            ram_we      <= 1'b1;
            last_issued <= walk_last;
          end
        end
        ST_FDONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fb_ctrl.sv
// tb/tb_pixel_fb_ctrl.sv - directed self-checking bench for pixel_fb_ctrl
module tb_pixel_fb_ctrl;

  localparam int PW = 4;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int AW = 5;
  localparam int CW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [PW-1:0] cpu_din = '0;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic [PW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          fill_start = 1'b0;
  logic [CW-1:0] fill_x0 = '0, fill_y0 = '0, fill_x1 = '0, fill_y1 = '0;
  logic [PW-1:0] fill_color = '0;
  logic          busy, fill_done;
  logic [AW-1:0] ram_addr;
  logic [PW-1:0] ram_din;
  logic          ram_we;
  logic [PW-1:0] ram_dout = '0;

  logic [PW-1:0] mem [0:31];
  int            log_addr [$];
  int            log_cyc [$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            total = 0;
  int            bad = 0;

  pixel_fb_ctrl #(
    .PIXEL_WIDTH (PW), .H_RES (HR), .V_RES (VR), .ADDR_WIDTH (AW), .COORD_WIDTH (CW)
  ) dut (
    .clock (clock), .reset (reset),
    .cpu_addr (cpu_addr), .cpu_din (cpu_din), .cpu_we (cpu_we), .cpu_re (cpu_re),
    .cpu_dout (cpu_dout), .cpu_ack (cpu_ack),
    .fill_start (fill_start), .fill_x0 (fill_x0), .fill_y0 (fill_y0),
    .fill_x1 (fill_x1), .fill_y1 (fill_y1), .fill_color (fill_color),
    .busy (busy), .fill_done (fill_done),
    .ram_addr (ram_addr), .ram_din (ram_din), .ram_we (ram_we), .ram_dout (ram_dout)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous DPRAM port 0 plus write log and fill_done counter.
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] = ram_din;
      log_addr.push_back(int'(ram_addr));
      log_cyc.push_back(cyc);
    end
    if (fill_done) done_cnt = done_cnt + 1;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    log_addr.delete();
    log_cyc.delete();
  endtask

  task automatic start_fill(input int x0, input int y0, input int x1, input int y1,
                            input logic [PW-1:0] c);
    fill_x0 = CW'(x0); fill_y0 = CW'(y0); fill_x1 = CW'(x1); fill_y1 = CW'(y1);
    fill_color = c;
    fill_start = 1'b1;
    @(negedge clock);
    fill_start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("busy_fall_in_time", n < 200, 1);
  endtask

  initial begin
    int d0, k;
    logic got, pb, pd, ppd;

    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state
    #1;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // CPU write addr 5 data A: ack and RAM port driven in N+1
    cpu_addr = 5; cpu_din = 4'hA; cpu_we = 1'b1;
    @(negedge clock);
    chk("wr_ack", cpu_ack, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 5);
    chk("wr_ram_din", ram_din, 4'hA);
    cpu_we = 1'b0;
    @(negedge clock);
    chk("wr_ack_drop", cpu_ack, 0);
    chk("wr_mem5", mem[5], 4'hA);

    // CPU read addr 5: ack at N+3 with data
    cpu_re = 1'b1;
    @(negedge clock);
    chk("rd_ack_n1", cpu_ack, 0);
    chk("rd_addr_n1", ram_addr, 5);
    @(negedge clock);
    chk("rd_ack_n2", cpu_ack, 0);
    @(negedge clock);
    chk("rd_ack_n3", cpu_ack, 1);
    chk("rd_dout", cpu_dout, 4'hA);
    cpu_re = 1'b0;
    @(negedge clock);
    chk("rd_ack_drop", cpu_ack, 0);
    chk("rd_dout_hold", cpu_dout, 4'hA);

    // Fill (1,1)-(3,2) colour 7
    clear_mem();
    mem[5] = 4'hA;
    d0 = done_cnt;
    start_fill(1, 1, 3, 2, 4'h7);
    wait_idle();
    chk("f1_nwrites", log_addr.size(), 6);
    if (log_addr.size() == 6) begin
      chk("f1_a0", log_addr[0], 9);
      chk("f1_a1", log_addr[1], 10);
      chk("f1_a2", log_addr[2], 11);
      chk("f1_a3", log_addr[3], 17);
      chk("f1_a4", log_addr[4], 18);
      chk("f1_a5", log_addr[5], 19);
      chk("f1_consecutive", log_cyc[5] - log_cyc[0], 5);
    end
    chk("f1_done_once", done_cnt - d0, 1);
    chk("f1_busy_low", busy, 0);
    chk("f1_mem18", mem[18], 4'h7);
    chk("f1_mem5_kept", mem[5], 4'hA);
    chk("f1_mem8_kept", mem[8], 0);
    chk("f1_mem12_kept", mem[12], 0);

    // Fill (6,2)-(20,9) colour 3 clips to (6,2)-(7,3)
    clear_mem();
    start_fill(6, 2, 20, 9, 4'h3);
    wait_idle();
    chk("f2_nwrites", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("f2_a0", log_addr[0], 22);
      chk("f2_a1", log_addr[1], 23);
      chk("f2_a2", log_addr[2], 30);
      chk("f2_a3", log_addr[3], 31);
    end

    // Empty fill (5,0)-(2,3)
    clear_mem();
    d0 = done_cnt;
    start_fill(5, 0, 2, 3, 4'h1);
    wait_idle();
    chk("f3_nwrites", log_addr.size(), 0);
    chk("f3_done_once", done_cnt - d0, 1);
    chk("f3_busy_low", busy, 0);

    // fill_start together with a CPU write: CPU first, fill afterwards
    clear_mem();
    cpu_addr = 0; cpu_din = 4'h1; cpu_we = 1'b1;
    start_fill(0, 0, 0, 0, 4'h2);
    chk("pend_cpu_ack", cpu_ack, 1);
    cpu_we = 1'b0;
    wait_idle();
    chk("pend_nwrites", log_addr.size(), 2);
    chk("pend_mem0", mem[0], 4'h2);

    // CPU write during full-screen fill; second fill_start ignored
    clear_mem();
    d0 = done_cnt;
    start_fill(0, 0, 7, 3, 4'h5);
    k = 0;
    while (!ram_we && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("fs_run_seen", ram_we, 1);
    cpu_addr = 3; cpu_din = 4'hC; cpu_we = 1'b1;
    fill_x0 = 0; fill_y0 = 0; fill_x1 = 0; fill_y1 = 0; fill_color = 4'h9;
    fill_start = 1'b1;
    pb = busy; pd = fill_done; ppd = 1'b0; got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      fill_start = 1'b0;
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
      ppd = pd; pd = fill_done; pb = busy;
    end
    chk("fs_ack_seen", got, 1);
    chk("fs_ack_after_idle", pb, 0);
    chk("fs_done_before_idle", ppd, 1);
    chk("fs_ack_addr", ram_addr, 3);
    cpu_we = 1'b0;
    repeat (5) @(negedge clock);
    chk("fs_busy_low", busy, 0);
    chk("fs_nwrites", log_addr.size(), 33);
    chk("fs_done_once", done_cnt - d0, 1);
    chk("fs_mem3", mem[3], 4'hC);
    chk("fs_mem0", mem[0], 4'h5);
    chk("fs_mem31", mem[31], 4'h5);

    // Reset at the 10th FRUN cycle of a full-screen fill
    clear_mem();
    d0 = done_cnt;
    start_fill(0, 0, 7, 3, 4'hF);
    k = 0;
    while (!ram_we && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("rr_run_seen", ram_we, 1);
    repeat (9) @(negedge clock);
    chk("rr_still_writing", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("rr_ram_we", ram_we, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ram_addr", ram_addr, 0);
    chk("rr_fill_done", fill_done, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rr_nwrites", log_addr.size(), 9);
    chk("rr_no_done", done_cnt - d0, 0);
    chk("rr_mem8", mem[8], 4'hF);
    chk("rr_mem9_untouched", mem[9], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
